// File: rtl/hazard_sequencer_pkg.sv
// Shared pipeline-control definitions for the RV32 hazard sequencer:
// register-zero constant, mul/div FSM states and the stage enable/NOP encodings.
package hazard_sequencer_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   typedef struct packed {
      logic pc_we;
      logic ifid_we;
      logic ifid_flush;
      logic idex_we;
      logic idex_bubble;
      logic exmem_we;
      logic exmem_bubble;
      logic memwb_bubble;
   } ctrl_t;

   // Bit order: pc_we ifid_we ifid_flush idex_we idex_bubble exmem_we exmem_bubble memwb_bubble
   localparam ctrl_t CTRL_FLOW     = ctrl_t'(8'b1101_0100);
   localparam ctrl_t CTRL_RESET    = ctrl_t'(8'b0010_1011);
   localparam ctrl_t CTRL_MEM_WAIT = ctrl_t'(8'b0000_0001);
   localparam ctrl_t CTRL_MD_WAIT  = ctrl_t'(8'b0000_0110);
   localparam ctrl_t CTRL_LU_WAIT  = ctrl_t'(8'b0001_1100);
   localparam ctrl_t CTRL_FLUSH    = ctrl_t'(8'b1111_0100);

   function automatic logic lu_hazard(input logic       mem_read,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2,
                                      input logic       uses_rs2);
      return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones.
// Zero latency to the output register; no backpressure.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_inc && (r_q != '1)) begin
         r_q <= r_q + W'(1);
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline; controls are combinational
// from the mul/div FSM and current hazards, with memory wait taking top priority.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             MemRead_IDEX,
   input  logic [4:0]       rd_IDEX,
   input  logic [4:0]       rs1_IFID,
   input  logic [4:0]       rs2_IFID,
   input  logic             uses_rs2_IFID,
   input  logic             branch_taken_ID,
   input  logic             muldiv_IDEX,
   input  logic             mem_req_EXMEM,
   input  logic             mem_ack_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             IFIDFlush_o,
   output logic             IDEXWrite_o,
   output logic             IDEXBubble_o,
   output logic             EXMEMWrite_o,
   output logic             EXMEMBubble_o,
   output logic             MEMWBBubble_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int              MD_W     = $clog2(MULDIV_LAT) + 1;
   localparam bit              MD_MULTI = (MULDIV_LAT > 1);
   localparam logic [MD_W-1:0] MD_LOAD  = MD_MULTI ? MD_W'(MULDIV_LAT - 2) : '0;

   md_state_e       r_state, w_state_nxt;
   logic [MD_W-1:0] r_md_cnt, w_md_cnt_nxt;
   logic            w_mem_stall, w_md_stall, w_lu_stall, w_flush;
   ctrl_t           w_ctrl;

   assign w_mem_stall = mem_req_EXMEM && !mem_ack_i;
   assign w_md_stall  = ((r_state == RUN) && muldiv_IDEX && MD_MULTI) ||
                        ((r_state == MD_BUSY) && (r_md_cnt != '0));
   assign w_lu_stall  = lu_hazard(MemRead_IDEX, rd_IDEX, rs1_IFID, rs2_IFID, uses_rs2_IFID);
   assign w_flush     = rst_i && branch_taken_ID && !w_mem_stall && !w_md_stall && !w_lu_stall;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state  <= RUN;
         r_md_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_md_cnt <= w_md_cnt_nxt;
      end
   end

   // The mul/div unit keeps computing under a memory wait, so the count runs regardless.
   always_comb begin
      w_state_nxt  = r_state;
      w_md_cnt_nxt = r_md_cnt;
      case (r_state)
         RUN: begin
            if (muldiv_IDEX && MD_MULTI) begin
               w_state_nxt  = MD_BUSY;
               w_md_cnt_nxt = MD_LOAD;
            end
         end
         MD_BUSY: begin
            if (r_md_cnt != '0) begin
               w_md_cnt_nxt = r_md_cnt - MD_W'(1);
            end else if (!w_mem_stall) begin
               w_state_nxt = RUN;
            end
         end
      endcase
   end

   always_comb begin
      w_ctrl = CTRL_FLOW;
      if (!rst_i) begin
         w_ctrl = CTRL_RESET;
      end else if (w_mem_stall) begin
         w_ctrl = CTRL_MEM_WAIT;
      end else if (w_md_stall) begin
         w_ctrl = CTRL_MD_WAIT;
      end else if (w_lu_stall) begin
         w_ctrl = CTRL_LU_WAIT;
      end else if (branch_taken_ID) begin
         w_ctrl = CTRL_FLUSH;
      end
   end

   assign PCWrite_o     = w_ctrl.pc_we;
   assign IFIDWrite_o   = w_ctrl.ifid_we;
   assign IFIDFlush_o   = w_ctrl.ifid_flush;
   assign IDEXWrite_o   = w_ctrl.idex_we;
   assign IDEXBubble_o  = w_ctrl.idex_bubble;
   assign EXMEMWrite_o  = w_ctrl.exmem_we;
   assign EXMEMBubble_o = w_ctrl.exmem_bubble;
   assign MEMWBBubble_o = w_ctrl.memwb_bubble;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_inc   (!w_ctrl.pc_we),
      .o_q     (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_inc   (w_flush),
      .o_q     (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus random traffic, two instances
// (LAT=4/32-bit counters and LAT=1/3-bit counters) against a cycle-level model.
module tb_hazard_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       MemRead_IDEX = 1'b0;
   logic [4:0] rd_IDEX = '0, rs1_IFID = '0, rs2_IFID = '0;
   logic       uses_rs2_IFID = 1'b0, branch_taken_ID = 1'b0, muldiv_IDEX = 1'b0;
   logic       mem_req_EXMEM = 1'b0, mem_ack_i = 1'b0;

   logic [1:0]  pcw, ifidw, ifidf, idexw, idexb, exmemw, exmemb, memwbb;
   logic [31:0] scnt0, fcnt0;
   logic [2:0]  scnt1, fcnt1;

   int checks = 0;
   int failures = 0;

   // model state: whether a mul/div is occupying EX and how many cycles it has been there
   bit     md_act [2];
   int     md_age [2];
   longint m_stall [2];
   longint m_flush [2];
   int     lat_of [2] = '{4, 1};
   longint cmax [2]   = '{64'hFFFF_FFFF, 64'd7};

   always #5 clk = ~clk;

   hazard_sequencer #(.MULDIV_LAT(4), .CNT_W(32)) u_dut0 (
      .clk_i(clk), .rst_i(rst_n), .MemRead_IDEX(MemRead_IDEX), .rd_IDEX(rd_IDEX),
      .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID), .uses_rs2_IFID(uses_rs2_IFID),
      .branch_taken_ID(branch_taken_ID), .muldiv_IDEX(muldiv_IDEX),
      .mem_req_EXMEM(mem_req_EXMEM), .mem_ack_i(mem_ack_i),
      .PCWrite_o(pcw[0]), .IFIDWrite_o(ifidw[0]), .IFIDFlush_o(ifidf[0]),
      .IDEXWrite_o(idexw[0]), .IDEXBubble_o(idexb[0]), .EXMEMWrite_o(exmemw[0]),
      .EXMEMBubble_o(exmemb[0]), .MEMWBBubble_o(memwbb[0]),
      .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0));

   hazard_sequencer #(.MULDIV_LAT(1), .CNT_W(3)) u_dut1 (
      .clk_i(clk), .rst_i(rst_n), .MemRead_IDEX(MemRead_IDEX), .rd_IDEX(rd_IDEX),
      .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID), .uses_rs2_IFID(uses_rs2_IFID),
      .branch_taken_ID(branch_taken_ID), .muldiv_IDEX(muldiv_IDEX),
      .mem_req_EXMEM(mem_req_EXMEM), .mem_ack_i(mem_ack_i),
      .PCWrite_o(pcw[1]), .IFIDWrite_o(ifidw[1]), .IFIDFlush_o(ifidf[1]),
      .IDEXWrite_o(idexw[1]), .IDEXBubble_o(idexb[1]), .EXMEMWrite_o(exmemw[1]),
      .EXMEMBubble_o(exmemb[1]), .MEMWBBubble_o(memwbb[1]),
      .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Expected {PCW, IFIDW, IFIDFlush, IDEXW, IDEXBubble, EXMEMW, EXMEMBubble, MEMWBBubble}
   function automatic logic [7:0] exp_outs(input int d);
      bit mem, md, lu;
      if (!rst_n) return 8'b0010_1011;
      mem = mem_req_EXMEM && !mem_ack_i;
      md  = md_act[d] ? (md_age[d] < lat_of[d] - 1) : (muldiv_IDEX && lat_of[d] > 1);
      lu  = MemRead_IDEX && rd_IDEX != 0 &&
            (rd_IDEX == rs1_IFID || (uses_rs2_IFID && rd_IDEX == rs2_IFID));
      if (mem)                  return 8'b0000_0001;
      else if (md)              return 8'b0000_0110;
      else if (lu)              return 8'b0001_1100;
      else if (branch_taken_ID) return 8'b1111_0100;
      return 8'b1101_0100;
   endfunction

   task automatic advance(input int d, input logic [7:0] e);
      bit mem;
      if (!rst_n) begin
         md_act[d] = 1'b0; md_age[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
         return;
      end
      if (!e[7] && m_stall[d] < cmax[d]) m_stall[d]++;
      if (e[5] && m_flush[d] < cmax[d]) m_flush[d]++;
      mem = mem_req_EXMEM && !mem_ack_i;
      if (md_act[d]) begin
         if (md_age[d] >= lat_of[d] - 1 && !mem) md_act[d] = 1'b0;
         else md_age[d]++;
      end else if (muldiv_IDEX && lat_of[d] > 1) begin
         md_act[d] = 1'b1;
         md_age[d] = 1;
      end
   endtask

   // One clock: compare everything mid-cycle, then step the model past the edge.
   task automatic cycle();
      logic [7:0] e [2];
      logic [7:0] o [2];
      longint     sa [2];
      longint     fa [2];
      @(negedge clk);
      o[0] = {pcw[0], ifidw[0], ifidf[0], idexw[0], idexb[0], exmemw[0], exmemb[0], memwbb[0]};
      o[1] = {pcw[1], ifidw[1], ifidf[1], idexw[1], idexb[1], exmemw[1], exmemb[1], memwbb[1]};
      sa[0] = longint'(scnt0); sa[1] = longint'(scnt1);
      fa[0] = longint'(fcnt0); fa[1] = longint'(fcnt1);
      for (int d = 0; d < 2; d++) begin
         e[d] = exp_outs(d);
         check($sformatf("outs%0d", d), o[d], e[d]);
         check($sformatf("stall_cnt%0d", d), sa[d], rst_n ? m_stall[d] : 0);
         check($sformatf("flush_cnt%0d", d), fa[d], rst_n ? m_flush[d] : 0);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) advance(d, e[d]);
   endtask

   task automatic idle();
      MemRead_IDEX = 1'b0; rd_IDEX = '0; rs1_IFID = '0; rs2_IFID = '0;
      uses_rs2_IFID = 1'b0; branch_taken_ID = 1'b0; muldiv_IDEX = 1'b0;
      mem_req_EXMEM = 1'b0; mem_ack_i = 1'b0;
   endtask

   initial begin
      idle();
      cycle(); cycle();
      rst_n = 1'b1;
      cycle();

      // load-use on rs2, then same with rd = x0
      MemRead_IDEX = 1'b1; rd_IDEX = 5'd5; rs1_IFID = 5'd1; rs2_IFID = 5'd5; uses_rs2_IFID = 1'b1;
      cycle(); idle(); cycle();
      check("lu_stall_cnt", scnt0, 32'd1);
      MemRead_IDEX = 1'b1; rd_IDEX = 5'd0; rs1_IFID = 5'd0; rs2_IFID = 5'd0; uses_rs2_IFID = 1'b1;
      cycle(); idle(); cycle();
      check("lu_x0_stall_cnt", scnt0, 32'd1);

      // plain taken branch, then branch held under a load-use stall
      branch_taken_ID = 1'b1;
      cycle(); idle(); cycle();
      check("br_flush_cnt", fcnt0, 32'd1);
      branch_taken_ID = 1'b1; MemRead_IDEX = 1'b1; rd_IDEX = 5'd3; rs1_IFID = 5'd3;
      cycle();
      MemRead_IDEX = 1'b0;
      cycle(); idle(); cycle();
      check("br_lu_flush_cnt", fcnt0, 32'd2);

      // two back-to-back mul/div ops
      muldiv_IDEX = 1'b1;
      repeat (8) cycle();
      idle(); cycle();
      check("md_b2b_stall_cnt", scnt0, 32'd8);
      check("md_lat1_stall_cnt", scnt1, 3'd2);

      // memory wait of five cycles, then ack without request
      mem_req_EXMEM = 1'b1;
      repeat (5) cycle();
      mem_ack_i = 1'b1;
      cycle(); idle(); cycle();
      check("mem_stall_cnt", scnt0, 32'd13);
      mem_ack_i = 1'b1;
      cycle(); idle(); cycle();
      check("ack_noreq_stall_cnt", scnt0, 32'd13);

      // memory wait overlapping a mul/div
      muldiv_IDEX = 1'b1;
      cycle();
      mem_req_EXMEM = 1'b1;
      repeat (6) cycle();
      mem_ack_i = 1'b1;
      cycle(); idle(); cycle();
      check("overlap_stall_cnt", scnt0, 32'd20);

      // reset while the mul/div count is still running
      muldiv_IDEX = 1'b1;
      cycle();
      rst_n = 1'b0;
      #1;
      check("rst_pcw", pcw[0], 1'b0);
      check("rst_exmemb", exmemb[0], 1'b1);
      check("rst_stall_cnt", scnt0, 32'd0);
      cycle();
      rst_n = 1'b1; idle();
      cycle();
      check("post_rst_pcw", pcw[0], 1'b1);
      check("post_rst_stall_cnt", scnt0, 32'd0);

      for (int n = 0; n < 400; n++) begin
         MemRead_IDEX    = ($urandom % 3) == 0;
         rd_IDEX         = 5'($urandom % 4);
         rs1_IFID        = 5'($urandom % 4);
         rs2_IFID        = 5'($urandom % 4);
         uses_rs2_IFID   = ($urandom % 2) == 0;
         branch_taken_ID = ($urandom % 4) == 0;
         muldiv_IDEX     = ($urandom % 5) == 0;
         mem_req_EXMEM   = ($urandom % 3) == 0;
         mem_ack_i       = ($urandom % 2) == 0;
         cycle();
      end
      idle(); cycle();
      check("sat_stall_cnt1", scnt1, 3'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline stall/flush controller for the 5-stage RV32 core.
- Sequences freeze and bubble insertion across PC, IF/ID, ID/EX, EX/MEM and MEM/WB for four causes:
  - load-use hazards
  - taken branches resolved in ID
  - multi-cycle mul/div occupying EX
  - memory wait on the data port in MEM
- Complements the forwarding logic: it stalls only where forwarding cannot cover the hazard.
- Keeps saturating stall and flush performance counters.

Parameters:
- MULDIV_LAT, 4: total cycles a mul/div op occupies EX; must be >= 1.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- MemRead_IDEX  in  1  load in EX.
- rd_IDEX  in  5  destination of the EX instruction.
- rs1_IFID  in  5  source 1 of the ID instruction.
- rs2_IFID  in  5  source 2 of the ID instruction.
- uses_rs2_IFID  in  1  ID instruction reads rs2.
- branch_taken_ID  in  1  branch/jump resolved taken in ID.
- muldiv_IDEX  in  1  mul/div op in EX.
- mem_req_EXMEM  in  1  load/store in MEM.
- mem_ack_i  in  1  data memory completes the MEM access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID write enable.
- IFIDFlush_o  out  1  IF/ID load NOP.
- IDEXWrite_o  out  1  ID/EX write enable.
- IDEXBubble_o  out  1  ID/EX load NOP.
- EXMEMWrite_o  out  1  EX/MEM write enable.
- EXMEMBubble_o  out  1  EX/MEM load NOP.
- MEMWBBubble_o  out  1  MEM/WB load NOP.
- stall_cnt_o  out  CNT_W  cycles with PCWrite_o=0, saturating.
- flush_cnt_o  out  CNT_W  IF/ID flushes, saturating.

Behaviour:
- FSM has two states, RUN and MD_BUSY, plus a down-counter md_cnt of width clog2(MULDIV_LAT)+1. Reset state: RUN, md_cnt=0, both counters 0.
- Outputs while rst_i=0:
  - all *Write_o = 0
  - all *Bubble_o / IFIDFlush_o = 1
  - counters = 0
- Outputs are combinational from state and inputs. Conditions are evaluated in priority order:
  - mem_stall = mem_req_EXMEM & ~mem_ack_i. Effect:
    - PC, IF/ID, ID/EX and EX/MEM writes = 0
    - MEMWBBubble_o = 1
    - no other bubble or flush
    - mem_ack_i without mem_req_EXMEM is ignored.
  - md_stall = (RUN & muldiv_IDEX & MULDIV_LAT>1) | (MD_BUSY & md_cnt!=0). Effect:
    - PC, IF/ID, ID/EX writes = 0
    - EXMEMBubble_o = 1.
  - lu_stall = MemRead_IDEX & rd_IDEX!=0 & (rd_IDEX==rs1_IFID | (uses_rs2_IFID & rd_IDEX==rs2_IFID)). Effect:
    - PC, IF/ID writes = 0
    - IDEXBubble_o = 1.
  - flush = branch_taken_ID & ~(any stall above). Effect: IFIDFlush_o = 1 and PCWrite_o = 1, taking the target.
- A branch in a stalled ID is held and re-evaluated the next cycle. It is never flushed twice.
- All write enables not named above are 1. Bubble and flush outputs never assert together with their own stage's write disabled.
- FSM transitions:
  - RUN -> MD_BUSY when muldiv_IDEX & MULDIV_LAT>1; md_cnt <= MULDIV_LAT-2.
  - MD_BUSY: md_cnt decrements each cycle, holding at 0.
  - MD_BUSY -> RUN when md_cnt==0 & ~mem_stall; EX advances that cycle.
  - The mul/div unit keeps computing during mem_stall, so md_cnt still decrements.
  - A mul/div op therefore occupies EX for max(MULDIV_LAT, memory-imposed) cycles.
- Back-to-back mul/div: the second op is detected in RUN the cycle after release, with no gap cycle.
- Counters:
  - stall_cnt_o increments on every cycle with PCWrite_o=0.
  - flush_cnt_o increments on every flush.
  - Both saturate at 2^CNT_W-1.
- Reset mid-MD_BUSY aborts to RUN immediately; asynchronous, no completion.

Decomposition:
- Shared pipeline package holds:
  - REG_ZERO (5'd0)
  - the state enum {RUN, MD_BUSY}
  - NOP encoding constants used by the bubble muxes.
- One sub-module, sat_counter (parameter W, inc, async active-low reset), instantiated twice for the counters.

Test Plan:
- Load-use: MemRead_IDEX=1, rd_IDEX=5, rs2_IFID=5, uses_rs2_IFID=1 -> one cycle with PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1; stall_cnt_o=1. Same case with rd_IDEX=0 -> no stall.
- Branch: branch_taken_ID=1, no hazard -> IFIDFlush_o=1 for 1 cycle, flush_cnt_o=1. Branch coincident with lu_stall -> no flush that cycle, flush the next.
- Mul/div, MULDIV_LAT=4: muldiv_IDEX=1 -> 3 stall cycles with EXMEMBubble_o=1, release on the 4th; back-to-back op -> 6 stalls total. MULDIV_LAT=1 -> zero stalls.
- Memory wait: mem_req_EXMEM=1, mem_ack_i=0 for 5 cycles, then 1 -> MEMWBBubble_o=1 and all upstream writes 0 for exactly 5 cycles; ack with req=0 -> no effect.
- Overlap: mem_stall of 6 cycles starting 1 cycle after mul/div entry (LAT=4) -> release only after ack; total stalled cycles = 7.
- Reset: rst_i low during MD_BUSY with md_cnt=2 -> immediate RUN, counters 0, writes 0 and bubbles 1 while rst_i low; normal flow after deassertion. Saturation: preload counter to 2^CNT_W-1 -> stays there.
